// File: rtl/i2c_controller.sv
`default_nettype none
// ============================================================================
// Module      : i2c_controller
// Description : Single-byte I2C controller (START, addr+R/W, ACK, data, STOP)
//               with push-pull SCL and open-drain SDA.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_controller #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       ack_error,
    output logic [7:0] rdata,
    output logic       scl_out,
    output logic       sda_oe,
    input  logic       sda_in
);

    localparam int                    c_QCNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_QCNT_W-1:0]   c_QCNT_MAX = c_QCNT_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_ADDR     = 3'd2,
        S_ADDR_ACK = 3'd3,
        S_DATA     = 3'd4,
        S_DATA_ACK = 3'd5,
        S_STOP     = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_QCNT_W-1:0] r_qcnt;
    logic [1:0]          r_quarter;
    logic [3:0]          r_bit_cnt;
    logic [7:0]          r_shift;
    logic [7:0]          r_wdata;
    logic [7:0]          r_rx;
    logic [7:0]          r_rdata;
    logic                r_rw;
    logic                r_ack_error;
    logic                r_done;
    logic                w_scl;
    logic                w_sda_oe;

    logic w_qend, w_pend, w_sample, w_last_bit, w_accept, w_nack_now;

    assign w_qend     = (r_qcnt == c_QCNT_MAX);
    assign w_pend     = w_qend && (r_quarter == 2'd3);
    assign w_sample   = (r_qcnt == '0) && (r_quarter == 2'd3);
    assign w_last_bit = (r_bit_cnt == 4'd7);
    // The done cycle still blocks a new request even though busy is already low.
    assign w_accept   = (r_state == S_IDLE) && start && !r_done;
    // With CLK_DIV=1 the ACK sample and the end of the bit fall on the same cycle.
    assign w_nack_now = r_ack_error | (w_sample & sda_in);

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_scl       = 1'b1;
        w_sda_oe    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = S_START;
            end
            S_START: begin
                w_scl    = (r_quarter != 2'd3);
                w_sda_oe = r_quarter[1];
                if (w_pend) w_state_nxt = S_ADDR;
            end
            S_ADDR: begin
                w_scl    = r_quarter[1];
                w_sda_oe = ~r_shift[7];
                if (w_pend && w_last_bit) w_state_nxt = S_ADDR_ACK;
            end
            S_ADDR_ACK: begin
                w_scl = r_quarter[1];
                if (w_pend) w_state_nxt = w_nack_now ? S_STOP : S_DATA;
            end
            S_DATA: begin
                w_scl    = r_quarter[1];
                w_sda_oe = ~r_rw & ~r_shift[7];
                if (w_pend && w_last_bit) w_state_nxt = S_DATA_ACK;
            end
            S_DATA_ACK: begin
                w_scl = r_quarter[1];
                if (w_pend) w_state_nxt = S_STOP;
            end
            S_STOP: begin
                w_scl    = (r_quarter != 2'd0);
                w_sda_oe = ~r_quarter[1];
                if (w_pend) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_qcnt      <= '0;
            r_quarter   <= 2'd0;
            r_bit_cnt   <= 4'd0;
            r_shift     <= 8'd0;
            r_wdata     <= 8'd0;
            r_rx        <= 8'd0;
            r_rdata     <= 8'd0;
            r_rw        <= 1'b0;
            r_ack_error <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= (r_state == S_STOP) && w_pend;
            if (r_state == S_IDLE) begin
                r_qcnt    <= '0;
                r_quarter <= 2'd0;
                r_bit_cnt <= 4'd0;
                if (w_accept) begin
                    r_shift     <= {addr, rw};
                    r_rw        <= rw;
                    r_wdata     <= wdata;
                    r_ack_error <= 1'b0;
                end
            end else begin
                r_qcnt <= w_qend ? '0 : r_qcnt + 1'b1;
                if (w_qend) r_quarter <= r_quarter + 2'd1;

                if (w_sample) begin
                    case (r_state)
                        S_ADDR_ACK: if (sda_in) r_ack_error <= 1'b1;
                        S_DATA:     if (r_rw) r_rx <= {r_rx[6:0], sda_in};
                        S_DATA_ACK: if (!r_rw && sda_in) r_ack_error <= 1'b1;
                        default:    ;
                    endcase
                end

                if (w_pend) begin
                    if (r_state == S_ADDR || r_state == S_DATA) begin
                        r_shift   <= {r_shift[6:0], 1'b0};
                        r_bit_cnt <= w_last_bit ? 4'd0 : r_bit_cnt + 4'd1;
                    end
                    if (r_state == S_ADDR_ACK) r_shift <= r_wdata;
                    // In a read, ack_error can only come from the address phase.
                    if (r_state == S_STOP && r_rw && !r_ack_error) r_rdata <= r_rx;
                end
            end
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign ack_error = r_ack_error;
    assign rdata     = r_rdata;
    assign scl_out   = w_scl;
    assign sda_oe    = w_sda_oe;

endmodule
`default_nettype wire

// File: tb/tb_i2c_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_controller
// Description : Self-checking bench for i2c_controller with a bus-level target
//               model and a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_controller;

    localparam int D = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] addr = 7'd0;
    logic [7:0] wdata = 8'd0;
    logic       busy, done, ack_error, scl_out, sda_oe;
    logic [7:0] rdata;
    logic       slave_pull = 1'b0;
    logic       sda_bus;

    assign sda_bus = ~(sda_oe | slave_pull);

    i2c_controller #(.CLK_DIV(D)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .rw       (rw),
        .addr     (addr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .ack_error(ack_error),
        .rdata    (rdata),
        .scl_out  (scl_out),
        .sda_oe   (sda_oe),
        .sda_in   (sda_bus)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic       cfg_ack_a = 1'b1;
    logic       cfg_ack_d = 1'b1;
    logic [7:0] cfg_rbyte = 8'd0;
    logic       q_bits[$];
    int         start_cnt = 0;
    int         stop_cnt  = 0;
    int         bit_idx   = 0;
    bit         in_txn    = 1'b0;
    logic       prev_scl  = 1'b1;
    logic       prev_sda  = 1'b1;
    logic [7:0] model_rdata = 8'd0;

    // Target model: decodes START/STOP, records bits at SCL rise, drives SDA while SCL is low.
    always begin
        logic cur_sda;
        @(posedge clk);
        #1;
        cur_sda = ~(sda_oe | slave_pull);
        if (scl_out === 1'b1 && prev_scl === 1'b1 && prev_sda === 1'b1 && cur_sda === 1'b0) begin
            start_cnt++;
            bit_idx = 0;
            in_txn  = 1'b1;
            q_bits.delete();
        end else if (scl_out === 1'b1 && prev_scl === 1'b1 && prev_sda === 1'b0 && cur_sda === 1'b1) begin
            stop_cnt++;
            in_txn     = 1'b0;
            slave_pull = 1'b0;
        end
        if (in_txn && prev_scl === 1'b0 && scl_out === 1'b1) begin
            q_bits.push_back(cur_sda);
            bit_idx++;
        end
        if (in_txn && prev_scl === 1'b1 && scl_out === 1'b0) begin
            if (bit_idx == 8)
                slave_pull = cfg_ack_a;
            else if (bit_idx >= 9 && bit_idx <= 16)
                slave_pull = cfg_ack_a && q_bits[7] && !cfg_rbyte[16 - bit_idx];
            else if (bit_idx == 17)
                slave_pull = cfg_ack_a && !q_bits[7] && cfg_ack_d;
            else
                slave_pull = 1'b0;
        end
        prev_scl = scl_out;
        prev_sda = ~(sda_oe | slave_pull);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] get_byte(input int base);
        logic [7:0] b;
        for (int i = 0; i < 8; i++)
            b[7-i] = (q_bits.size() > base + i) ? q_bits[base+i] : 1'bx;
        return b;
    endfunction

    // Entered and left at #1 after a rising edge.
    task automatic run_txn(input logic [6:0] a, input logic r, input logic [7:0] wd,
                           input logic aa, input logic ad, input logic [7:0] rb,
                           input bit poke, input bit hold);
        int         cyc;
        int         st0, sp0, exp_lat;
        logic       exp_err;
        logic [7:0] exp_rd;
        exp_lat     = aa ? 80 * D + 1 : 44 * D + 1;
        exp_err     = !aa || (!r && !ad);
        exp_rd      = (r && aa) ? rb : model_rdata;
        model_rdata = exp_rd;
        cfg_ack_a = aa;
        cfg_ack_d = ad;
        cfg_rbyte = rb;
        st0 = start_cnt;
        sp0 = stop_cnt;

        start = 1'b1; addr = a; rw = r; wdata = wd;
        @(posedge clk); #1;
        cyc   = 1;
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("ack_error_cleared", ack_error, 0);
        while (done !== 1'b1 && cyc < 100 * D) begin
            start = poke && (cyc == 20);
            if (start) begin addr = ~a; rw = ~r; wdata = ~wd; end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check("done_seen", done, 1);
        check("done_latency", cyc, exp_lat);
        check("busy_on_done", busy, 0);
        check("ack_error", ack_error, exp_err);
        check("rdata", rdata, exp_rd);
        check("addr_byte", get_byte(0), {a, r});
        check("addr_ack_bit", q_bits.size() > 8 ? q_bits[8] : 1'bx, !aa);
        check("bit_count", q_bits.size(), aa ? 19 : 10);
        check("start_cond", start_cnt - st0, 1);
        check("stop_cond", stop_cnt - sp0, 1);
        if (aa) begin
            check("data_byte", get_byte(9), r ? rb : wd);
            check("data_ack_bit", q_bits.size() > 17 ? q_bits[17] : 1'bx, r ? 1'b1 : !ad);
        end
        if (hold) begin
            start = 1'b1; addr = 7'h7F; rw = 1'b0; wdata = 8'hFF;
        end
        @(posedge clk); #1;
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_scl", scl_out, 1);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ack_error", ack_error, 0);
        check("rst_rdata", rdata, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Abort in the middle of the address byte.
        cfg_ack_a = 1'b1;
        start = 1'b1; addr = 7'h33; rw = 1'b0; wdata = 8'h0F;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("mid_busy_before_reset", busy, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_scl", scl_out, 1);
        check("mid_rst_sda_oe", sda_oe, 0);
        check("mid_rst_busy", busy, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_txn(7'h55, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
        run_txn(7'h2A, 1'b1, 8'h00, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
        run_txn(7'h11, 1'b1, 8'h00, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0);
        run_txn(7'h4C, 1'b0, 8'h3C, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        // Ignored starts while busy and on the done cycle; the next one is accepted.
        run_txn(7'h11, 1'b0, 8'h99, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
        run_txn(7'h60, 1'b0, 8'h81, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0);

        for (int k = 0; k < 6; k++) begin
            run_txn(7'($urandom), 1'($urandom), 8'($urandom),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                    8'($urandom), 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
